// File: rtl/cnn_conv_stream_feeder_if.sv
// Feeder bus: memory load ports, start/status and the pixel/weight streams.
// checksum is present only when CNN_FEEDER_CHECKSUM_EN is defined.
interface cnn_conv_stream_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PA_W       = 14,
  parameter int WA_W       = 11
);
  logic                  pxl_wr_en;
  logic [PA_W-1:0]       pxl_wr_addr;
  logic [DATA_WIDTH-1:0] pxl_wr_data;
  logic                  wgt_wr_en;
  logic [WA_W-1:0]       wgt_wr_addr;
  logic [DATA_WIDTH-1:0] wgt_wr_data;
  logic                  start;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_pxl_out;
  logic [DATA_WIDTH-1:0] weight_out;
  logic                  valid_weight_out;
  logic                  busy;
  logic                  done;
`ifdef CNN_FEEDER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;
`endif

  modport master (
    input  pxl_wr_en, pxl_wr_addr, pxl_wr_data,
    input  wgt_wr_en, wgt_wr_addr, wgt_wr_data, start,
`ifdef CNN_FEEDER_CHECKSUM_EN
    output checksum,
`endif
    output pxl_out, valid_pxl_out, weight_out, valid_weight_out, busy, done
  );

  modport slave (
    output pxl_wr_en, pxl_wr_addr, pxl_wr_data,
    output wgt_wr_en, wgt_wr_addr, wgt_wr_data, start,
`ifdef CNN_FEEDER_CHECKSUM_EN
    input  checksum,
`endif
    input  pxl_out, valid_pxl_out, weight_out, valid_weight_out, busy, done
  );
endinterface

// File: rtl/cnn_conv_stream_feeder.sv
// Holds one feature map and one weight set and streams both, gap-free, into the conv block.
// Optional running XOR of the pixel stream when CNN_FEEDER_CHECKSUM_EN is defined.
module cnn_conv_stream_feeder #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_WIDTH     = 16,
  parameter int IMAGE_HEIGHT    = 16,
  parameter int CHANNEL_NUM_IN  = 64,
  parameter int CHANNEL_NUM_OUT = 2,
  parameter int KERNEL          = 3
) (
  input logic                      clk,
  input logic                      reset,
  cnn_conv_stream_feeder_if.master fd
);
  localparam int PIXEL_NUM  = CHANNEL_NUM_IN * IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int WEIGHT_NUM = CHANNEL_NUM_IN * CHANNEL_NUM_OUT * KERNEL * KERNEL;
  localparam int PA_W       = $clog2(PIXEL_NUM);
  localparam int WA_W       = $clog2(WEIGHT_NUM);
  localparam logic [PA_W:0] PXL_LIM = (PA_W+1)'(PIXEL_NUM);
  localparam logic [WA_W:0] WGT_LIM = (WA_W+1)'(WEIGHT_NUM);

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] pxl_mem [PIXEL_NUM];
  logic [DATA_WIDTH-1:0] wgt_mem [WEIGHT_NUM];

  logic [PA_W:0]         pxl_cnt;
  logic [WA_W:0]         wgt_cnt;
  logic                  reading, pxl_rd, wgt_rd;
  logic [DATA_WIDTH-1:0] pxl_p0, wgt_p0;
  logic                  vld_pxl_p0, vld_wgt_p0;
  logic [DATA_WIDTH-1:0] pxl_p1, wgt_p1;
  logic                  vld_pxl_p1, vld_wgt_p1;

  assign reading = (state == PREFETCH) || (state == STREAM);
  assign pxl_rd  = reading && (pxl_cnt < PXL_LIM);
  assign wgt_rd  = reading && (wgt_cnt < WGT_LIM);

  // Leave STREAM only once every read has been issued and the read stage has drained.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (fd.start) state_nxt = PREFETCH;
      PREFETCH: state_nxt = STREAM;
      STREAM:   if (!pxl_rd && !wgt_rd && !vld_pxl_p0 && !vld_wgt_p0) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Stage p0: memory load port and synchronous read
  always_ff @(posedge clk) begin
    if (state == IDLE && fd.pxl_wr_en && ({1'b0, fd.pxl_wr_addr} < PXL_LIM))
      pxl_mem[fd.pxl_wr_addr] <= fd.pxl_wr_data;
    if (state == IDLE && fd.wgt_wr_en && ({1'b0, fd.wgt_wr_addr} < WGT_LIM))
      wgt_mem[fd.wgt_wr_addr] <= fd.wgt_wr_data;
    if (pxl_rd) pxl_p0 <= pxl_mem[pxl_cnt[PA_W-1:0]];
    if (wgt_rd) wgt_p0 <= wgt_mem[wgt_cnt[WA_W-1:0]];
  end

  // Stage p1: output registers, zeroed whenever their valid is low
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pxl_cnt    <= '0;
      wgt_cnt    <= '0;
      vld_pxl_p0 <= 1'b0;
      vld_wgt_p0 <= 1'b0;
      vld_pxl_p1 <= 1'b0;
      vld_wgt_p1 <= 1'b0;
      pxl_p1     <= '0;
      wgt_p1     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        pxl_cnt <= '0;
        wgt_cnt <= '0;
      end else begin
        if (pxl_rd) pxl_cnt <= pxl_cnt + 1'b1;
        if (wgt_rd) wgt_cnt <= wgt_cnt + 1'b1;
      end
      vld_pxl_p0 <= pxl_rd;
      vld_wgt_p0 <= wgt_rd;
      vld_pxl_p1 <= vld_pxl_p0;
      vld_wgt_p1 <= vld_wgt_p0;
      pxl_p1     <= vld_pxl_p0 ? pxl_p0 : '0;
      wgt_p1     <= vld_wgt_p0 ? wgt_p0 : '0;
    end
  end

  assign fd.pxl_out          = pxl_p1;
  assign fd.valid_pxl_out    = vld_pxl_p1;
  assign fd.weight_out       = wgt_p1;
  assign fd.valid_weight_out = vld_wgt_p1;
  assign fd.busy             = (state == STREAM);
  assign fd.done             = (state == DONE);

`ifdef CNN_FEEDER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  // Cleared in PREFETCH so the zero shows on the same cycle busy rises; held through done.
  always_ff @(posedge clk) begin
    if (reset || state == PREFETCH) checksum_q <= '0;
    else if (vld_pxl_p1)            checksum_q <= checksum_q ^ pxl_p1;
  end

  assign fd.checksum = checksum_q;
`endif
endmodule

// File: tb/tb_cnn_conv_stream_feeder.sv
// Directed bench for cnn_conv_stream_feeder: a default-size instance and a 2x2 single-channel instance.
module tb_cnn_conv_stream_feeder;
  localparam int DW    = 32;
  localparam int BG_P  = 16384;
  localparam int BG_W  = 1152;
  localparam int BG_PA = 14;
  localparam int BG_WA = 11;
  localparam int SM_P  = 4;
  localparam int SM_W  = 18;
  localparam int SM_PA = 2;
  localparam int SM_WA = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic        sel;
  logic        start, pxl_wr_en, wgt_wr_en;
  logic [15:0] pxl_wr_addr, wgt_wr_addr;
  logic [31:0] pxl_wr_data, wgt_wr_data;

  cnn_conv_stream_feeder_if #(.DATA_WIDTH(DW), .PA_W(BG_PA), .WA_W(BG_WA)) bg_if ();
  cnn_conv_stream_feeder_if #(.DATA_WIDTH(DW), .PA_W(SM_PA), .WA_W(SM_WA)) sm_if ();

  assign bg_if.start       = start & ~sel;
  assign bg_if.pxl_wr_en   = pxl_wr_en & ~sel;
  assign bg_if.pxl_wr_addr = pxl_wr_addr[BG_PA-1:0];
  assign bg_if.pxl_wr_data = pxl_wr_data;
  assign bg_if.wgt_wr_en   = wgt_wr_en & ~sel;
  assign bg_if.wgt_wr_addr = wgt_wr_addr[BG_WA-1:0];
  assign bg_if.wgt_wr_data = wgt_wr_data;

  assign sm_if.start       = start & sel;
  assign sm_if.pxl_wr_en   = pxl_wr_en & sel;
  assign sm_if.pxl_wr_addr = pxl_wr_addr[SM_PA-1:0];
  assign sm_if.pxl_wr_data = pxl_wr_data;
  assign sm_if.wgt_wr_en   = wgt_wr_en & sel;
  assign sm_if.wgt_wr_addr = wgt_wr_addr[SM_WA-1:0];
  assign sm_if.wgt_wr_data = wgt_wr_data;

  cnn_conv_stream_feeder bg_dut (.clk(clk), .reset(reset), .fd(bg_if));

  cnn_conv_stream_feeder #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
    .CHANNEL_NUM_IN(1), .CHANNEL_NUM_OUT(2), .KERNEL(3)
  ) sm_dut (.clk(clk), .reset(reset), .fd(sm_if));

  logic [31:0] o_pxl, o_wgt;
  logic        o_vp, o_vw, o_busy, o_done;
  assign o_pxl  = sel ? sm_if.pxl_out          : bg_if.pxl_out;
  assign o_wgt  = sel ? sm_if.weight_out       : bg_if.weight_out;
  assign o_vp   = sel ? sm_if.valid_pxl_out    : bg_if.valid_pxl_out;
  assign o_vw   = sel ? sm_if.valid_weight_out : bg_if.valid_weight_out;
  assign o_busy = sel ? sm_if.busy             : bg_if.busy;
  assign o_done = sel ? sm_if.done             : bg_if.done;
`ifdef CNN_FEEDER_CHECKSUM_EN
  logic [31:0] o_cs;
  assign o_cs = sel ? sm_if.checksum : bg_if.checksum;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // Pixel memory image: address for the big map, one-hot for the 2x2 map.
  function automatic logic [31:0] exp_pxl(input int a);
    if (sel) return (a >= 0 && a < 32) ? (32'd1 << a) : 32'd0;
    return 32'(a);
  endfunction

  task automatic load(input int np, input int nw);
    int n;
    n = (np > nw) ? np : nw;
    for (int a = 0; a < n; a++) begin
      pxl_wr_en   = (a < np);
      pxl_wr_addr = 16'(a);
      pxl_wr_data = exp_pxl(a);
      wgt_wr_en   = (a < nw);
      wgt_wr_addr = 16'(a);
      wgt_wr_data = 32'h1000 + 32'(a);
      @(posedge clk); #1;
    end
    pxl_wr_en = 1'b0;
    wgt_wr_en = 1'b0;
  endtask

  // One start; k counts edges after the edge that sampled start.
  task automatic run(input string tag, input int np, input int nw,
                     input int start_k, input int wr_k, input int rst_k);
    int len, last, err, vp_n, vw_n, busy_n, done_n;
    logic e_vp, e_vw, e_busy, e_done, idle;
    logic [31:0] e_pxl, e_wgt, e_cs;
    len  = (np > nw) ? np : nw;
    last = (rst_k != 0) ? rst_k + 20 : len + 6;
    err = 0; vp_n = 0; vw_n = 0; busy_n = 0; done_n = 0;
    e_cs = 32'd0;
    for (int a = 0; a < np; a++) e_cs = e_cs ^ exp_pxl(a);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      idle   = (rst_k != 0) && (k > rst_k);
      e_busy = !idle && (k >= 1) && (k <= len + 1);
      e_vp   = !idle && (k >= 2) && (k <= np + 1);
      e_vw   = !idle && (k >= 2) && (k <= nw + 1);
      e_done = !idle && (k == len + 2);
      e_pxl  = e_vp ? exp_pxl(k - 2) : 32'd0;
      e_wgt  = e_vw ? 32'h1000 + 32'(k - 2) : 32'd0;
      if ({o_busy, o_vp, o_vw, o_done} !== {e_busy, e_vp, e_vw, e_done} ||
          o_pxl !== e_pxl || o_wgt !== e_wgt) err++;
      vp_n   += int'(o_vp);
      vw_n   += int'(o_vw);
      busy_n += int'(o_busy);
      done_n += int'(o_done);
      if (k == 1 || k == 2 || k == 7 || k == np + 1 || k == np + 2 || k == nw + 1 ||
          k == nw + 2 || k == len + 2 || k == len + 3 || (rst_k != 0 && k == rst_k + 1)) begin
        check($sformatf("%s k%0d pxl_out", tag, k), o_pxl, e_pxl);
        check($sformatf("%s k%0d valid_pxl", tag, k), 32'(o_vp), 32'(e_vp));
        check($sformatf("%s k%0d weight_out", tag, k), o_wgt, e_wgt);
        check($sformatf("%s k%0d valid_wgt", tag, k), 32'(o_vw), 32'(e_vw));
        check($sformatf("%s k%0d busy", tag, k), 32'(o_busy), 32'(e_busy));
        check($sformatf("%s k%0d done", tag, k), 32'(o_done), 32'(e_done));
      end
`ifdef CNN_FEEDER_CHECKSUM_EN
      if (k == 1) check($sformatf("%s checksum cleared", tag), o_cs, 32'd0);
      if (rst_k == 0 && (k == len + 2 || k == len + 3))
        check($sformatf("%s k%0d checksum", tag, k), o_cs, e_cs);
`endif
      start     = (k == start_k);
      reset     = (rst_k != 0) && (k == rst_k);
      pxl_wr_en = (k == wr_k);
      if (k == wr_k) begin
        pxl_wr_addr = 16'd5;
        pxl_wr_data = 32'hDEADBEEF;
      end
    end
    start = 1'b0; reset = 1'b0; pxl_wr_en = 1'b0;
    check({tag, " cycle errors"}, 32'(err), 32'd0);
    check({tag, " valid_pxl cycles"}, 32'(vp_n), 32'((rst_k != 0) ? rst_k - 1 : np));
    check({tag, " valid_wgt cycles"}, 32'(vw_n), 32'((rst_k != 0) ? rst_k - 1 : nw));
    check({tag, " busy cycles"}, 32'(busy_n), 32'((rst_k != 0) ? rst_k : len + 1));
    check({tag, " done pulses"}, 32'(done_n), 32'((rst_k != 0) ? 0 : 1));
  endtask

  initial begin
    sel = 1'b0; start = 1'b0; reset = 1'b1;
    pxl_wr_en = 1'b0; wgt_wr_en = 1'b0;
    pxl_wr_addr = '0; wgt_wr_addr = '0; pxl_wr_data = '0; wgt_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      check($sformatf("reset%0d pxl_out", s), o_pxl, 32'd0);
      check($sformatf("reset%0d valid_pxl", s), 32'(o_vp), 32'd0);
      check($sformatf("reset%0d weight_out", s), o_wgt, 32'd0);
      check($sformatf("reset%0d valid_wgt", s), 32'(o_vw), 32'd0);
      check($sformatf("reset%0d busy", s), 32'(o_busy), 32'd0);
      check($sformatf("reset%0d done", s), 32'(o_done), 32'd0);
    end
    sel = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    load(BG_P, BG_W);
    run("run1", BG_P, BG_W, 49, 60, 0);
    run("midrst", BG_P, BG_W, 0, 0, 100);
    run("run3", BG_P, BG_W, 0, 0, 0);

    sel = 1'b1;
    #1;
    load(SM_P, SM_W);
    run("small1", SM_P, SM_W, 0, 0, 0);
    run("small2", SM_P, SM_W, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cnn_conv_stream_feeder.md
Name: cnn_conv_stream_feeder

Overview:
- Transmit side of the convolution input interface: holds one input feature map (CHANNEL_NUM_IN planes, each IMAGE_WIDTH x IMAGE_HEIGHT) and one weight set (CHANNEL_NUM_IN x CHANNEL_NUM_OUT x KERNEL x KERNEL) in internal memories.
- On start, streams both sets into cnn_conv_3x3_dilation_multi_channel_new through its pxl_in/valid_in and weight_in/valid_weight_in ports, gap-free.
- Replaces file-driven stimulus when the conv layers are chained on hardware.

Parameters:
- DATA_WIDTH, 32, word width of pixels and weights.
- IMAGE_WIDTH, 16, pixels per row.
- IMAGE_HEIGHT, 16, rows per plane.
- CHANNEL_NUM_IN, 64, input planes.
- CHANNEL_NUM_OUT, 2, output planes; sets the weight count.
- KERNEL, 3, kernel width.
- Derived: PIXEL_NUM = CHANNEL_NUM_IN*IMAGE_WIDTH*IMAGE_HEIGHT; WEIGHT_NUM = CHANNEL_NUM_IN*CHANNEL_NUM_OUT*KERNEL*KERNEL; PA_W = $clog2(PIXEL_NUM); WA_W = $clog2(WEIGHT_NUM).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pxl_wr_en  in  1  pixel memory write strobe.
- pxl_wr_addr  in  PA_W  pixel write address, channel-major then row-major.
- pxl_wr_data  in  DATA_WIDTH  pixel write data.
- wgt_wr_en  in  1  weight memory write strobe.
- wgt_wr_addr  in  WA_W  weight write address.
- wgt_wr_data  in  DATA_WIDTH  weight write data.
- start  in  1  single-cycle request to begin streaming.
- pxl_out  out  DATA_WIDTH  pixel to the conv block's pxl_in.
- valid_pxl_out  out  1  pixel valid; drives the conv block's valid_in.
- weight_out  out  DATA_WIDTH  weight to the conv block's weight_in.
- valid_weight_out  out  1  weight valid; drives the conv block's valid_weight_in.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when both streams have finished.

Behaviour:
- Reset values: pxl_out=0, weight_out=0, valid_pxl_out=0, valid_weight_out=0, busy=0, done=0. Internal counters are cleared and the FSM returns to IDLE. Memory contents are kept across reset.
- FSM states:
  - IDLE: start=1 moves to PREFETCH. Otherwise stays in IDLE.
  - PREFETCH: one cycle; issues the synchronous reads of address 0 from both memories. Moves to STREAM.
  - STREAM: each cycle presents the previously read words and reads the next addresses. Moves to DONE when both counters are exhausted.
  - DONE: one cycle; done=1. Returns to IDLE.
- Latency: start sampled at edge T. busy=1 from T+1. The first valid_pxl_out and valid_weight_out (element 0) appear at T+2.
- Pixel stream: valid_pxl_out is high for exactly PIXEL_NUM consecutive cycles. It carries addresses 0..PIXEL_NUM-1 in order with no gaps.
- Weight stream: starts on the same cycle as the pixel stream. valid_weight_out is high for exactly WEIGHT_NUM consecutive cycles, then drops to 0 while pixels continue.
- If WEIGHT_NUM > PIXEL_NUM, the pixel stream ends first and the weight stream continues alone.
- Data outputs are 0 on every cycle their valid is low. No stale data is presented.
- done asserts on the cycle after the last valid of the longer stream. busy deasserts on that same cycle.
- Writes are accepted only in IDLE, one word per memory per cycle. pxl_wr_en and wgt_wr_en may be high together. Writes in any other state are silently dropped.
- start outside IDLE is ignored; there is no queued restart. start and a write in the same IDLE cycle: the write commits and streaming begins.
- Out-of-range write addresses (pxl_wr_addr >= PIXEL_NUM or wgt_wr_addr >= WEIGHT_NUM) are dropped.
- reset mid-stream: at the next edge all valids go to 0, busy=0, and no done pulse is issued. A following start restarts from address 0.
- Counters are sized PA_W+1 and WA_W+1 so the terminal compare never wraps.

Optional Feature:
- Macro: CNN_FEEDER_CHECKSUM_EN.
- When defined:
  - Adds output checksum [DATA_WIDTH-1:0], a running XOR of every pixel_out word with valid_pxl_out=1 during the current run.
  - checksum is cleared to 0 on the cycle busy rises and on reset.
  - The final value is held from done until the next start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Pixel memory load with value = address and weight memory load with value = address+0x1000, then start → first valids at T+2; pxl_out 0..16383 on 16384 consecutive cycles; weight_out 0x1000..0x147F on 1152 consecutive cycles; done at T+2+16384; busy high exactly 16385 cycles.
- Second start while busy at cycle T+50 → ignored; stream continues unchanged; exactly one done pulse.
- Writes during STREAM of 0xDEADBEEF to pixel address 5 → dropped; a second run still outputs 5 at address 5.
- reset asserted at T+100 → valids 0 at the next edge; no done; a restart outputs address 0 first, with memory contents intact.
- Parameter override CHANNEL_NUM_IN=1, IMAGE 2x2, CHANNEL_NUM_OUT=2 (WEIGHT_NUM=18 > PIXEL_NUM=4) → pixel valid for 4 cycles, weight valid for 18 cycles, done after the 18th weight.
- With CNN_FEEDER_CHECKSUM_EN and pixels {1,2,4,8} in a 2x2 single-channel map → checksum=0x0000000F after done; cleared to 0 at the next run's busy rise.
